// File: rtl/ps2_ascii_feeder.sv
// ps2_ascii_feeder
//
// Turns PS/2 key events into the 8-bit character codes used by the CoCo keyboard
// matrix emulator. Codes are queued in a small FIFO and replayed one at a time.
// Each code is held for HOLD_CYCLES, then followed by GAP_CYCLES of 8'h00, so that
// back-to-back keys are never merged or lost.
//
// Optional feature: define KBD_SHIFT_XLAT_EN to track the shift keys and use the
// shifted translations. Without it, the unshifted code is always produced.
//
// Ports
//   clk           in   system clock (single domain)
//   reset         in   synchronous active-high reset
//   ps2_key[10:0] in   [10] toggles per event, [9] make, [8] E0-extended, [7:0] scancode
//   keyboard_data out  current character code, 8'h00 when idle or in the gap
//   done          out  one-cycle pulse coincident with the first cycle of a new code
//   overflow      out  one-cycle pulse when a translated code is dropped (FIFO full)
//   busy          out  FIFO non-empty or output FSM not idle
module ps2_ascii_feeder #(
  parameter int unsigned FIFO_AW     = 3,
  parameter logic [23:0] HOLD_CYCLES = 24'd2_000_000,
  parameter logic [23:0] GAP_CYCLES  = 24'd500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic [7:0]  keyboard_data,
  output logic        done,
  output logic        overflow,
  output logic        busy
);

  localparam int unsigned   Depth     = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] PtrOne = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [23:0]   HoldLoad  = HOLD_CYCLES - 24'd1;
  localparam logic [23:0]   GapLoad   = GAP_CYCLES - 24'd1;

  typedef enum logic [1:0] {StIdle, StPress, StGap} state_e;

  // ---------------------------------------------------------------------------
  // Event detect
  // ---------------------------------------------------------------------------
  logic       toggle_q;
  logic       key_evt;
  logic       key_make;
  logic       key_ext;
  logic [7:0] key_sc;

  assign key_evt  = ps2_key[10] ^ toggle_q;
  assign key_make = ps2_key[9];
  assign key_ext  = ps2_key[8];
  assign key_sc   = ps2_key[7:0];

  // Loaded unconditionally, including during reset, so no event appears after reset.
  always_ff @(posedge clk) begin
    toggle_q <= ps2_key[10];
  end

  // ---------------------------------------------------------------------------
  // Shift tracking
  // ---------------------------------------------------------------------------
  logic shift;

`ifdef KBD_SHIFT_XLAT_EN
  logic lshift_q;
  logic rshift_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
    end else if (key_evt && !key_ext) begin
      if (key_sc == 8'h12) lshift_q <= key_make;
      if (key_sc == 8'h59) rshift_q <= key_make;
    end
  end

  assign shift = lshift_q | rshift_q;
`else
  assign shift = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Translation. Shift scancodes fall into the default arm, so they are consumed
  // but never enqueued.
  // ---------------------------------------------------------------------------
  logic [7:0] xlat_code;
  logic       xlat_hit;

  always_comb begin
    xlat_code = 8'h00;
    xlat_hit  = 1'b1;
    if (key_ext) begin
      case (key_sc)
        8'h75:   xlat_code = 8'h41;
        8'h72:   xlat_code = 8'h42;
        8'h6B:   xlat_code = 8'h44;
        8'h74:   xlat_code = 8'h43;
        8'h6C:   xlat_code = 8'h7f;
        default: xlat_hit  = 1'b0;
      endcase
    end else begin
      case (key_sc)
        8'h1C: xlat_code = 8'h61;
        8'h32: xlat_code = 8'h62;
        8'h21: xlat_code = 8'h63;
        8'h23: xlat_code = 8'h64;
        8'h24: xlat_code = 8'h65;
        8'h2B: xlat_code = 8'h66;
        8'h34: xlat_code = 8'h67;
        8'h33: xlat_code = 8'h68;
        8'h43: xlat_code = 8'h69;
        8'h3B: xlat_code = 8'h6a;
        8'h42: xlat_code = 8'h6b;
        8'h4B: xlat_code = 8'h6c;
        8'h3A: xlat_code = 8'h6d;
        8'h31: xlat_code = 8'h6e;
        8'h44: xlat_code = 8'h6f;
        8'h4D: xlat_code = 8'h70;
        8'h15: xlat_code = 8'h71;
        8'h2D: xlat_code = 8'h72;
        8'h1B: xlat_code = 8'h73;
        8'h2C: xlat_code = 8'h74;
        8'h3C: xlat_code = 8'h75;
        8'h2A: xlat_code = 8'h76;
        8'h1D: xlat_code = 8'h77;
        8'h22: xlat_code = 8'h78;
        8'h35: xlat_code = 8'h79;
        8'h1A: xlat_code = 8'h7a;
        8'h45: xlat_code = 8'h30;
        8'h16: xlat_code = shift ? 8'h21 : 8'h31;
        8'h1E: xlat_code = shift ? 8'h22 : 8'h32;
        8'h26: xlat_code = shift ? 8'h23 : 8'h33;
        8'h25: xlat_code = shift ? 8'h24 : 8'h34;
        8'h2E: xlat_code = shift ? 8'h25 : 8'h35;
        8'h36: xlat_code = shift ? 8'h26 : 8'h36;
        8'h3D: xlat_code = shift ? 8'h27 : 8'h37;
        8'h3E: xlat_code = shift ? 8'h28 : 8'h38;
        8'h46: xlat_code = shift ? 8'h29 : 8'h39;
        8'h41: xlat_code = shift ? 8'h3c : 8'h2c;
        8'h49: xlat_code = shift ? 8'h3e : 8'h2e;
        8'h4A: xlat_code = shift ? 8'h3f : 8'h2f;
        8'h4C: xlat_code = shift ? 8'h2b : 8'h3b;
        8'h52: xlat_code = shift ? 8'h2a : 8'h3a;
        8'h4E: xlat_code = 8'h5f;
        8'h55: xlat_code = 8'h3d;
        8'h29: xlat_code = 8'h20;
        8'h5A: xlat_code = 8'h0d;
        8'h76: xlat_code = 8'h08;
        8'h66: xlat_code = 8'h44;
        default: xlat_hit = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [Depth];
  logic [FIFO_AW:0] wr_ptr_q;
  logic [FIFO_AW:0] rd_ptr_q;
  logic             fifo_empty;
  logic             fifo_full;
  logic             wr_req;
  logic             wr_en;
  logic             pop;
  logic             ovf_d;
  state_e           state_q;
  logic [23:0]      cnt_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop        = (state_q == StIdle) && !fifo_empty;
  assign wr_req     = key_evt && key_make && xlat_hit;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_en      = wr_req && (!fifo_full || pop);
  assign ovf_d      = wr_req && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
    end else if (wr_en) begin
      wr_ptr_q <= wr_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= xlat_code;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rd_ptr_q      <= '0;
      keyboard_data <= 8'h00;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      done     <= 1'b0;
      overflow <= ovf_d;
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            keyboard_data <= mem_q[rd_ptr_q[FIFO_AW-1:0]];
            done          <= 1'b1;
            cnt_q         <= HoldLoad;
            rd_ptr_q      <= rd_ptr_q + PtrOne;
            state_q       <= StPress;
          end
        end
        StPress: begin
          if (cnt_q == 24'd0) begin
            keyboard_data <= 8'h00;
            cnt_q         <= GapLoad;
            state_q       <= StGap;
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        StGap: begin
          if (cnt_q == 24'd0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_ps2_ascii_feeder.sv
// Self-checking bench for ps2_ascii_feeder. A queue-based reference model predicts
// launch times arithmetically (launch, hold window, gap) and translates keys from
// lookup tables; every cycle's outputs are compared against it.
module tb_ps2_ascii_feeder;

  localparam int Hold  = 20;
  localparam int Gap   = 5;
  localparam int Aw    = 3;
  localparam int Depth = 8;

  localparam logic [7:0] LETTER_SC [0:25] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
    8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGIT_SC [0:9] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] PUNCT_SC [0:6] = '{8'h41, 8'h49, 8'h4A, 8'h4C, 8'h52, 8'h4E, 8'h55};
  localparam logic [7:0] PUNCT_LO [0:6] = '{8'h2c, 8'h2e, 8'h2f, 8'h3b, 8'h3a, 8'h5f, 8'h3d};
  localparam logic [7:0] PUNCT_HI [0:6] = '{8'h3c, 8'h3e, 8'h3f, 8'h2b, 8'h2a, 8'h5f, 8'h3d};
  localparam logic [7:0] CTRL_SC  [0:3] = '{8'h29, 8'h5A, 8'h76, 8'h66};
  localparam logic [7:0] CTRL_CH  [0:3] = '{8'h20, 8'h0d, 8'h08, 8'h44};
  localparam logic [7:0] EXT_SC   [0:4] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h6C};
  localparam logic [7:0] EXT_CH   [0:4] = '{8'h41, 8'h42, 8'h44, 8'h43, 8'h7f};
  localparam logic [7:0] POOL     [0:11] = '{
    8'h1C, 8'h16, 8'h45, 8'h41, 8'h4C, 8'h12, 8'h59, 8'h6B, 8'h5A, 8'h05, 8'h52, 8'h75};

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [7:0]  keyboard_data;
  logic        done;
  logic        overflow;
  logic        busy;

  ps2_ascii_feeder #(
    .FIFO_AW    (Aw),
    .HOLD_CYCLES(24'(Hold)),
    .GAP_CYCLES (24'(Gap))
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_key      (ps2_key),
    .keyboard_data(keyboard_data),
    .done         (done),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int obs_done = 0;
  int obs_ovf  = 0;

  // Reference model state
  logic [7:0] m_q[$];
  int         launch_at   = -1000;
  logic [7:0] launch_code = 8'h00;
  int         free_at     = 0;
  bit         m_ovf       = 1'b0;
  bit         lsh         = 1'b0;
  bit         rsh         = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void ref_xlat(input bit ext, input logic [7:0] sc, input bit sh,
                                   output logic [7:0] code, output bit ok);
    code = 8'h00;
    ok   = 1'b0;
    if (ext) begin
      for (int i = 0; i < 5; i++) if (EXT_SC[i] == sc) begin code = EXT_CH[i]; ok = 1'b1; end
    end else begin
      for (int i = 0; i < 26; i++)
        if (LETTER_SC[i] == sc) begin code = 8'(8'h61 + i); ok = 1'b1; end
      for (int i = 0; i < 10; i++)
        if (DIGIT_SC[i] == sc) begin
          code = (sh && i != 0) ? 8'(8'h20 + i) : 8'(8'h30 + i);
          ok   = 1'b1;
        end
      for (int i = 0; i < 7; i++)
        if (PUNCT_SC[i] == sc) begin code = sh ? PUNCT_HI[i] : PUNCT_LO[i]; ok = 1'b1; end
      for (int i = 0; i < 4; i++) if (CTRL_SC[i] == sc) begin code = CTRL_CH[i]; ok = 1'b1; end
    end
  endfunction

  // One clock cycle: check this cycle's outputs, drive this cycle's inputs, advance model.
  task automatic step(input bit ev, input bit mk, input bit ext, input logic [7:0] sc,
                      input bit rst);
    logic [7:0] code;
    bit         ok;
    bit         sh;
    bit         do_pop;
    @(posedge clk);
    #1;
    check_eq("done", 32'(done), 32'(cyc == launch_at));
    check_eq("keyboard_data", 32'(keyboard_data),
             (cyc >= launch_at && cyc < launch_at + Hold) ? 32'(launch_code) : 32'h0);
    check_eq("busy", 32'(busy), 32'(m_q.size() != 0 || cyc < free_at));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    if (done === 1'b1) obs_done++;
    if (overflow === 1'b1) obs_ovf++;

    reset = rst;
    if (ev) ps2_key = {~ps2_key[10], mk, ext, sc};
    else    ps2_key[9:0] = 10'($urandom);

    if (rst) begin
      m_q.delete();
      launch_at = -1000;
      free_at   = 0;
      m_ovf     = 1'b0;
      lsh       = 1'b0;
      rsh       = 1'b0;
    end else begin
      m_ovf  = 1'b0;
      do_pop = (m_q.size() > 0) && (cyc >= free_at);
      if (do_pop) begin
        launch_code = m_q.pop_front();
        launch_at   = cyc + 1;
        free_at     = cyc + 1 + Hold + Gap;
      end
`ifdef KBD_SHIFT_XLAT_EN
      sh = lsh | rsh;
`else
      sh = 1'b0;
`endif
      if (ev) begin
        if (!ext && sc == 8'h12)      lsh = mk;
        else if (!ext && sc == 8'h59) rsh = mk;
        else if (mk) begin
          ref_xlat(ext, sc, sh, code, ok);
          if (ok) begin
            if (m_q.size() < Depth) m_q.push_back(code);
            else m_ovf = 1'b1;
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic key(input bit mk, input bit ext, input logic [7:0] sc);
    step(1'b1, mk, ext, sc, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (m_q.size() != 0 || cyc <= free_at); i++) idle(1);
  endtask

  int d0;
  int o0;

  initial begin
    reset   = 1'b1;
    ps2_key = 11'h000;
    @(posedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("reset_busy", 32'(busy), 32'h0);
    check_eq("reset_data", 32'(keyboard_data), 32'h0);
    idle(3);

    // Single letter
    d0 = obs_done;
    key(1'b1, 1'b0, 8'h1C);
    idle(2);
    check_eq("a_launch_data", 32'(keyboard_data), 32'h61);
    drain();
    check_eq("a_done_count", 32'(obs_done - d0), 32'd1);

    // Shifted digit (31 when shift translation is disabled)
    key(1'b1, 1'b0, 8'h12);
    key(1'b1, 1'b0, 8'h16);
    key(1'b0, 1'b0, 8'h16);
    key(1'b0, 1'b0, 8'h12);
    drain();

    // Extended left then enter, consecutive events
    key(1'b1, 1'b1, 8'h6B);
    key(1'b1, 1'b0, 8'h5A);
    drain();

    // Overflow: hold FSM in PRESS, then nine makes
    d0 = obs_done;
    o0 = obs_ovf;
    key(1'b1, 1'b0, 8'h1C);
    idle(3);
    for (int i = 0; i < 8; i++) key(1'b1, 1'b0, 8'h1C);
    key(1'b1, 1'b0, 8'h32);
    idle(2);
    check_eq("ovf_count", 32'(obs_ovf - o0), 32'd1);
    // Write coincident with the pop from a full FIFO
    for (int i = 0; i < 100 && cyc < free_at; i++) idle(1);
    key(1'b1, 1'b0, 8'h21);
    drain();
    check_eq("ovf_done_count", 32'(obs_done - d0), 32'd10);
    check_eq("ovf_no_more", 32'(obs_ovf - o0), 32'd1);

    // Break-only and unmapped make
    d0 = obs_done;
    key(1'b0, 1'b0, 8'h1C);
    key(1'b0, 1'b1, 8'h75);
    key(1'b1, 1'b0, 8'h05);
    key(1'b1, 1'b1, 8'h1C);
    idle(4);
    check_eq("ignored_done", 32'(obs_done - d0), 32'd0);

    // Reset mid-PRESS with three queued
    for (int i = 0; i < 4; i++) key(1'b1, 1'b0, DIGIT_SC[i + 2]);
    idle(6);
    d0 = obs_done;
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    idle(Hold + Gap + 10);
    check_eq("reset_mid_done", 32'(obs_done - d0), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      end else if ($urandom_range(0, 5) == 0) begin
        logic [7:0] sc;
        sc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : POOL[$urandom_range(0, 11)];
        key(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), sc);
      end else begin
        idle(1);
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_ascii_feeder.md
# ps2_ascii_feeder

Converts PS/2 key events into the 8-bit character codes the CoCo keyboard matrix emulator consumes, and queues them in a small FIFO. Codes are replayed one at a time as `keyboard_data` plus a one-cycle `done` strobe, followed by a silent gap, so that fast typing and bursts are never lost or merged. Sits between the PS/2 front end and the matrix block that drives `kb_rows` from `kb_cols`.

## Interface
- `FIFO_AW`, 3: FIFO address width; depth = 2^FIFO_AW entries.
- `HOLD_CYCLES`, 24'd2_000_000: cycles a code is presented after `done`; must be < 24'hFFFF00.
- `GAP_CYCLES`, 24'd500_000: cycles `keyboard_data` = 8'h00 between codes.
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: synchronous, active-high reset.
- `ps2_key` in 11: [10] toggles once per event, [9] 1 = make / 0 = break, [8] E0-extended, [7:0] scancode.
- `keyboard_data` out 8: current character code; 8'h00 when idle or in gap.
- `done` out 1: one-cycle pulse when a new code is launched; registered, glitch-free.
- `overflow` out 1: one-cycle pulse when a translated code is dropped because the FIFO is full.
- `busy` out 1: high while FIFO non-empty or the output FSM is not IDLE.

## Operation
- Event detect: register `ps2_key[10]`; an event is any cycle where it differs from the registered copy. Process at most one event per cycle.
- Shift tracking: scancodes 8'h12 / 8'h59 (non-extended) set or clear `lshift` / `rshift` on make / break. `shift = lshift | rshift`. Shift events are never enqueued.
- Break events: ignored except for shift tracking.
- Make translation (unshifted / shifted):
  - Letters: map to 8'h61–8'h7a, with shift ignored.
  - Digits 0–9: map to 8'h30–8'h39. Shifted 1–9 map to 8'h21–8'h29. Shifted 0 maps to 8'h30.
  - Punctuation:
    - `,` gives 2c / 3c.
    - `.` gives 2e / 3e.
    - `/` gives 2f / 3f.
    - `;` gives 3b / 2b.
    - `'` gives 3a / 2a.
    - `-` gives 5f / 5f.
    - `=` gives 3d / 3d.
  - Control keys: space → 20, enter (5A) → 0d, esc (76) → 08 (break), backspace (66) → 44 (left).
  - Extended keys: E0 75 → 41, E0 72 → 42, E0 6B → 44, E0 74 → 43, E0 6C → 7f (clear).
- Any other make code is dropped silently.
- FIFO behaviour:
  - A translated code is written in the cycle after the event.
  - Full + write drops the new code, leaves contents unchanged, and pulses `overflow`.
  - Simultaneous write and read with FIFO full succeeds: the read frees the slot.
  - Pointers wrap modulo depth, with an extra MSB for full/empty.
- Output FSM:
  - IDLE: if FIFO non-empty, pop, load `keyboard_data`, pulse `done`, load counter = HOLD_CYCLES-1, and go to PRESS.
  - PRESS: hold the code while counting down. At 0, set `keyboard_data` = 0, load counter = GAP_CYCLES-1, and go to GAP.
  - GAP: count down. At 0, go to IDLE.
- Reset values: `keyboard_data` = 00, `done` = 0, `overflow` = 0, `busy` = 0, FSM = IDLE, FIFO empty, `lshift` = `rshift` = 0.
- The registered `ps2_key[10]` copy is loaded from the input during reset, so no spurious event follows reset.
- Reset mid-PRESS: outputs return to reset values on the next edge, and queued codes are discarded.

## Timing
- Event → FIFO write: 1 cycle.
- Write into an empty FIFO with FSM in IDLE → `done` high and `keyboard_data` valid 2 cycles after the event cycle.
- `done` is high for exactly 1 cycle, coincident with the first cycle of the new `keyboard_data`.
- Code period = HOLD_CYCLES + GAP_CYCLES + 1 cycles (the extra cycle is IDLE), with back-to-back queued codes.
- Counters are 24 bits wide. HOLD_CYCLES and GAP_CYCLES must be ≥ 1.

## Configuration
- `KBD_SHIFT_XLAT_EN` defined: shift state is tracked and the shifted column above applies.
- Not defined:
  - Shift registers are removed and the unshifted code is always used.
  - The `shift` term is constant 0.
  - Shift scancodes are still consumed, not enqueued.

## Test plan
- Reset, then make 1C (A) → one `done` pulse, `keyboard_data` = 61 for HOLD_CYCLES cycles, then 00 for GAP_CYCLES cycles, `busy` falls.
- Make 12, make 16, break 16, break 12 → single code 21. Without `KBD_SHIFT_XLAT_EN` → 31.
- E0 6B make, then 5A make, in consecutive events → codes 44 then 0d, with `done` pulses exactly HOLD_CYCLES + GAP_CYCLES + 1 apart.
- Nine makes of 1C with the FSM held in PRESS, so nothing pops, FIFO_AW = 3:
  - 8 queued, and the ninth pulses `overflow`.
  - Exactly 8 `done` pulses follow.
  - A write coincident with a pop while full is accepted.
- Break-only events and unmapped make 05 → no `done`, no FIFO write, `busy` stays 0.
- Assert `reset` mid-PRESS with 3 codes queued → next cycle `keyboard_data` = 00, `busy` = 0, and no further `done` pulses.
